// File: rtl/gemm_pkg.sv
// gemm_pkg: shared widths, lanes per word and FSM state encoding for the GEMM weight reader
package gemm_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int LANE_W = 16;
  localparam int LANES_PER_WORD = DATA_W / LANE_W;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/gemm_word_fifo.sv
// gemm_word_fifo: 2-entry word buffer (wr_en/wr_data push, rd_en pop, rd_data head word, count occupancy)
module gemm_word_fifo import gemm_pkg::*; #(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count
);
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  assign rd_data = mem_q[rp_q];
  assign count = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wp_q] = wr_data;
    wp_d = wp_q ^ wr_en;
    rp_d = rp_q ^ rd_en;
    cnt_d = cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gemm_weight_reader.sv
// gemm_weight_reader: bursts num_words ROM words from base_addr (rom_addr/rom_data, 1-cycle latency) out as fp16 lanes on a valid/ready stream with out_last, busy and done
module gemm_weight_reader import gemm_pkg::*; #(
  parameter int ADDR_W = gemm_pkg::ADDR_W,
  parameter int DATA_W = gemm_pkg::DATA_W,
  parameter int LANE_W = gemm_pkg::LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int LPW = DATA_W / LANE_W;
  localparam int LW = $clog2(LPW);
  localparam int NW = ADDR_W + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [NW-1:0] num_q, num_d, iss_q, iss_d, pop_cnt_q, pop_cnt_d;
  logic [LW-1:0] lane_q, lane_d;
  logic rd_q, rd_d, dv_q, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] head;
  logic [1:0] cnt, inflight;
  logic hs, pop, issue, ok, accept, last_lane;
  gemm_word_fifo #(.DW(DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(dv_q), .wr_data(rom_data),
    .rd_en(pop), .rd_data(head), .count(cnt)
  );
  assign out_valid = cnt != 2'd0;
  assign last_lane = lane_q == LW'(LPW - 1);
  assign out_data = out_valid ? head[DATA_W-1-LANE_W*int'(lane_q) -: LANE_W] : '0;
  assign out_last = out_valid && last_lane && pop_cnt_q == num_q - 1'b1;
  assign hs = out_valid && out_ready;
  assign pop = hs && last_lane;
  assign ok = num_words != '0 && num_words <= NW'(2 ** ADDR_W);
  assign accept = state_q == S_IDLE && start && ok;
  assign inflight = {1'b0, rd_q} + {1'b0, dv_q};
  assign issue = state_q == S_FETCH && iss_q != num_q && inflight < 2'd2 - cnt;
  assign rom_addr = rom_addr_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = (state_q == S_IDLE && start) ? (ok ? S_FETCH : S_DONE) :
              (state_q == S_FETCH && iss_q == num_q) ? S_DRAIN :
              (state_q == S_DRAIN && hs && out_last) ? S_DONE :
              (state_q == S_DONE) ? S_IDLE : state_q;
    rom_addr_d = accept ? base_addr : issue ? rom_addr_q + 1'b1 : rom_addr_q;
    num_d = accept ? num_words : num_q;
    iss_d = accept ? NW'(1) : issue ? iss_q + 1'b1 : iss_q;
    rd_d = accept || issue;
    lane_d = accept ? '0 : hs ? lane_q + 1'b1 : lane_q;
    pop_cnt_d = accept ? '0 : pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rom_addr_q <= '0;
      num_q <= '0;
      iss_q <= '0;
      pop_cnt_q <= '0;
      lane_q <= '0;
      rd_q <= 1'b0;
      dv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rom_addr_q <= rom_addr_d;
      num_q <= num_d;
      iss_q <= iss_d;
      pop_cnt_q <= pop_cnt_d;
      lane_q <= lane_d;
      rd_q <= rd_d;
      dv_q <= rd_q;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
